// File: rtl/p3_restriction_sweeper.sv
// p3_restriction_sweeper
// Drives every input pattern of an 8-input benchmark function that is consistent
// with a programmed restriction (fixed bits held, free bits enumerated in
// ascending order). It samples y0 once per pattern and reports the ones count,
// the pattern count and whether the restricted function is constant.
//
// Optional feature macro: P3_SWEEP_SIGNATURE_EN
//   When defined, a 16-bit MISR (x^16+x^12+x^5+1) of the samples is reported
//   on output sig.
//
// Handshake: start is a request that is accepted only while the sweeper is idle.
// busy is high from the cycle after acceptance until the last sample. done is a
// one-cycle pulse that marks the results as valid, and busy is low in that cycle.
// The results and x_out then hold until the next accepted start. There is no
// backpressure.
//
// The FSM state is kept in the signal 'state' so that checkers can bind to it.

module p3_restriction_sweeper #(
    parameter int SAMPLE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] fix_mask,
    input  logic [7:0] fix_val,
    output logic [7:0] x_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic [8:0] ones_count,
    output logic [8:0] pat_count,
    output logic       is_const,
    output logic       const_val
`ifdef P3_SWEEP_SIGNATURE_EN
    ,
    output logic [15:0] sig
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // With zero settle latency, a new pattern is sampled in the cycle it appears.
    localparam state_t     FIRST_ST  = (SAMPLE_LAT == 0) ? S_SAMPLE : S_HOLD;
    localparam logic [3:0] HOLD_LAST = 4'((SAMPLE_LAT == 0) ? 0 : SAMPLE_LAT - 1);

    state_t     state;
    logic [7:0] mask_q;
    logic [7:0] val_q;
    logic [3:0] hold_cnt;
    logic [8:0] inc;
    logic [7:0] nxt;
    logic       last;

    // Masked increment. Forcing the fixed bits to 1 lets the carry ripple past
    // them, so the free bits count in ascending binary order. A carry out of
    // bit 7 means the pattern that was just sampled was the last one.
    always_comb begin
        inc  = {1'b0, x_out | mask_q} + 9'd1;
        last = inc[8];
        nxt  = (inc[7:0] & ~mask_q) | val_q;
    end

    // Sweep sequencer: accept, settle, sample, advance, report.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            mask_q     <= 8'd0;
            val_q      <= 8'd0;
            hold_cnt   <= 4'd0;
            x_out      <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ones_count <= 9'd0;
            pat_count  <= 9'd0;
            is_const   <= 1'b0;
            const_val  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mask_q     <= fix_mask;
                        val_q      <= fix_val & fix_mask;
                        x_out      <= fix_val & fix_mask;
                        ones_count <= 9'd0;
                        pat_count  <= 9'd0;
                        is_const   <= 1'b1;
                        const_val  <= 1'b0;
                        hold_cnt   <= 4'd0;
                        busy       <= 1'b1;
                        state      <= FIRST_ST;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= 4'd0;
                        state    <= S_SAMPLE;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    pat_count  <= pat_count + 9'd1;
                    ones_count <= ones_count + {8'd0, y_in};
                    if (pat_count == 9'd0) begin
                        const_val <= y_in;
                    end else if (y_in != const_val) begin
                        is_const <= 1'b0;
                    end
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        x_out <= nxt;
                        state <= FIRST_ST;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef P3_SWEEP_SIGNATURE_EN
    // Sample signature: this is a Galois MISR. One shift happens per sample, and
    // y_in is folded into bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= 16'hFFFF;
        end else if (state == S_IDLE && start) begin
            sig <= 16'hFFFF;
        end else if (state == S_SAMPLE) begin
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'd0, y_in};
        end
    end
`else
    // Signature logic is not built in this configuration.
`endif

endmodule
